// File: rtl/ram_pkg.sv
// Shared types for the byte-addressable data RAM: access sizes, FSM states
// and the size-to-byte-count helper used by both datapath and alignment logic.
package ram_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10,
    SIZE_D = 2'b11
  } size_e;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  function automatic int unsigned size_bytes(size_e s);
    return 32'd1 << s;
  endfunction

endpackage

// File: rtl/ram_lane_align.sv
// Lane steering for the byte RAM: load-side shift and sign/zero extension,
// store-side byte strobe and lane-replicated write data.
module ram_lane_align
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OFF_W      = 2
) (
  input  logic [DATA_WIDTH-1:0]   ld_word,
  input  logic [OFF_W-1:0]        ld_off,
  input  size_e                   ld_size,
  input  logic                    ld_uns,
  output logic [DATA_WIDTH-1:0]   ld_data,
  input  logic [DATA_WIDTH-1:0]   st_wdata,
  input  logic [OFF_W-1:0]        st_off,
  input  size_e                   st_size,
  output logic [DATA_WIDTH/8-1:0] st_strb,
  output logic [DATA_WIDTH-1:0]   st_data
);

  localparam int NB = DATA_WIDTH / 8;

  function automatic logic [DATA_WIDTH-1:0] low_mask(int unsigned nbits);
    if (nbits >= DATA_WIDTH) return '1;
    return (DATA_WIDTH'(1) << nbits) - DATA_WIDTH'(1);
  endfunction

  logic [DATA_WIDTH-1:0] ld_shift;
  logic [DATA_WIDTH-1:0] ld_mask;
  logic                  ld_sign;
  logic [DATA_WIDTH-1:0] st_rep;
  int unsigned           st_nb;

  // The mask's top set bit marks the access MSB; a full-width mask leaves the word untouched.
  assign ld_shift = ld_word >> {ld_off, 3'b000};
  assign ld_mask  = low_mask(size_bytes(ld_size) << 3);
  assign ld_sign  = |(ld_shift & (ld_mask ^ (ld_mask >> 1)));
  assign ld_data  = (ld_uns || !ld_sign) ? (ld_shift & ld_mask) : (ld_shift | ~ld_mask);

  assign st_nb  = size_bytes(st_size);
  assign st_rep = st_wdata & low_mask(st_nb << 3);

  always_comb begin
    st_data = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      if ((i % st_nb) == 0) st_data = st_data | (st_rep << (i * 8));
    end
    if (st_nb >= NB) st_strb = {NB{1'b1}};
    else             st_strb = ((NB'(1) << st_nb) - NB'(1)) << st_off;
  end

endmodule

// File: rtl/byte_ram.sv
// Byte-addressable RV32I data RAM: post-reset clear sweep, strobed stores,
// extended loads, misalignment errors and a configurable response latency.
module byte_ram
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 256,
  parameter int READ_LATENCY = 1,
  localparam int ADDR_WIDTH  = $clog2(DEPTH * DATA_WIDTH / 8)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  size_e                 req_size,
  input  logic                  req_unsigned,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error
);

  localparam int unsigned NB = DATA_WIDTH / 8;
  localparam int OFF_W       = $clog2(NB);
  localparam int IDX_W       = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   clr_cnt;
  logic               clr_we;

  logic [OFF_W-1:0]   off;
  logic [IDX_W-1:0]   idx;
  logic               size_ok, align_ok, req_err, acc, st_we, ld_re;
  logic [NB-1:0]      st_strb;
  logic [DATA_WIDTH-1:0] st_data, ld_data;

  logic                  vld_p0, err_p0, wr_p0, uns_p0;
  logic [OFF_W-1:0]      off_p0;
  size_e                 size_p0;
  logic [DATA_WIDTH-1:0] word_p0, dat_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (clr_we) clr_cnt <= clr_cnt + IDX_W'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    clr_we    = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_we = 1'b1;
        if (clr_cnt == IDX_W'(DEPTH - 1)) state_d = READY;
      end
      READY:   req_ready = 1'b1;
      default: state_d = CLEAR;
    endcase
  end

  assign off      = req_addr[OFF_W-1:0];
  assign idx      = req_addr[OFF_W +: IDX_W];
  assign size_ok  = size_bytes(req_size) <= NB;
  assign align_ok = (off & OFF_W'(size_bytes(req_size) - 1)) == '0;
  assign req_err  = !size_ok || !align_ok;
  assign acc      = req_valid && req_ready;
  assign st_we    = acc && req_write && !req_err;
  assign ld_re    = acc && !req_write && !req_err;

  ram_lane_align #(
    .DATA_WIDTH (DATA_WIDTH),
    .OFF_W      (OFF_W)
  ) u_align (
    .ld_word  (word_p0),
    .ld_off   (off_p0),
    .ld_size  (size_p0),
    .ld_uns   (uns_p0),
    .ld_data  (ld_data),
    .st_wdata (req_wdata),
    .st_off   (off),
    .st_size  (req_size),
    .st_strb  (st_strb),
    .st_data  (st_data)
  );

  // Stage p0: array write/read on the accept edge
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_cnt] <= '0;
    end else if (st_we) begin
      for (int i = 0; i < NB; i++) begin
        if (st_strb[i]) mem[idx][i*8 +: 8] <= st_data[i*8 +: 8];
      end
    end
    if (ld_re) word_p0 <= mem[idx];
    if (acc) begin
      err_p0  <= req_err;
      wr_p0   <= req_write;
      off_p0  <= off;
      size_p0 <= req_size;
      uns_p0  <= req_unsigned;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_p0 <= 1'b0;
    else     vld_p0 <= acc;
  end

  assign dat_p0 = (err_p0 || wr_p0) ? '0 : ld_data;

  logic                  vld_c [READ_LATENCY];
  logic                  err_c [READ_LATENCY];
  logic [DATA_WIDTH-1:0] dat_c [READ_LATENCY];

  assign vld_c[0] = vld_p0;
  assign err_c[0] = err_p0;
  assign dat_c[0] = dat_p0;

  // Stages p1..pN: extended response delayed to the configured latency
  for (genvar k = 1; k < READ_LATENCY; k++) begin : g_stage
    logic                  vld_pn, err_pn;
    logic [DATA_WIDTH-1:0] dat_pn;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) vld_pn <= 1'b0;
      else     vld_pn <= vld_c[k-1];
    end

    always_ff @(posedge clk) begin
      err_pn <= err_c[k-1];
      dat_pn <= dat_c[k-1];
    end

    assign vld_c[k] = vld_pn;
    assign err_c[k] = err_pn;
    assign dat_c[k] = dat_pn;
  end

  // Data registers are not reset; gating by valid gives zero outputs after reset.
  assign rsp_valid = vld_c[READ_LATENCY-1];
  assign rsp_error = rsp_valid && err_c[READ_LATENCY-1];
  assign rsp_rdata = rsp_valid ? dat_c[READ_LATENCY-1] : '0;

endmodule

// File: tb/tb_byte_ram.sv
// Randomized and directed bench for byte_ram against a byte-array reference
// model with an in-order expected-response queue.
module tb_byte_ram;
  import ram_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 256;
  localparam int RL    = 3;
  localparam int AW    = 10;

  logic          clk;
  logic          rst;
  logic          req_valid, req_ready, req_write, req_unsigned;
  logic [AW-1:0] req_addr;
  size_e         req_size;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_error;
  logic [DW-1:0] rsp_rdata;

  byte_ram #(
    .DATA_WIDTH   (DW),
    .DEPTH        (DEPTH),
    .READ_LATENCY (RL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_error    (rsp_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  mb [DEPTH*4];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          clr_edges = 0;
  bit          mdl_ready = 0;
  bit          fix_en = 0;
  logic [31:0] fix_d = 0;
  bit          fix_e = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mdl_load(logic [AW-1:0] addr, int nb, bit uns);
    logic [31:0]   v;
    logic [AW-1:0] a;
    v = 0;
    for (int k = 0; k < nb; k++) begin
      a = addr + AW'(k);
      v = v | (32'(mb[a]) << (8 * k));
    end
    if (nb < 4 && !uns && ((v >> (8 * nb - 1)) & 32'd1) != 0)
      v = v | ~((32'd1 << (8 * nb)) - 32'd1);
    return v;
  endfunction

  task automatic model_reset();
    q.delete();
    mdl_ready = 0;
    clr_edges = 0;
    for (int i = 0; i < DEPTH * 4; i++) mb[i] = 8'h00;
  endtask

  task automatic model_accept();
    int            nb;
    bit            err;
    logic [31:0]   d;
    logic [AW-1:0] a;
    exp_t          e;
    nb  = 1 << int'(req_size);
    err = (nb > 4) || ((int'(req_addr) % nb) != 0);
    d   = 0;
    if (!err && req_write) begin
      for (int k = 0; k < nb; k++) begin
        a = req_addr + AW'(k);
        mb[a] = 8'(req_wdata >> (8 * k));
      end
    end else if (!err) begin
      d = mdl_load(req_addr, nb, req_unsigned);
    end
    e.due  = cyc + RL - 1;
    e.data = fix_en ? fix_d : d;
    e.err  = fix_en ? fix_e : err;
    q.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    cyc++;
    if (req_valid && mdl_ready && !rst) model_accept();
    if (!rst && !mdl_ready) begin
      clr_edges++;
      if (clr_edges == DEPTH) mdl_ready = 1;
    end
    @(negedge clk);
    check("req_ready", 32'(req_ready), 32'(mdl_ready));
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      check("rsp_valid", 32'(rsp_valid), 32'd1);
      check("rsp_error", 32'(rsp_error), 32'(e.err));
      check("rsp_rdata", rsp_rdata, e.data);
    end else begin
      check("rsp_idle", 32'(rsp_valid), 32'd0);
    end
  endtask

  task automatic drive(bit w, int addr, int sz, bit uns, logic [31:0] wd);
    req_valid    = 1'b1;
    req_write    = w;
    req_addr     = AW'(addr);
    req_size     = size_e'(2'(sz));
    req_unsigned = uns;
    req_wdata    = wd;
    step();
  endtask

  task automatic dreq(bit w, int addr, int sz, bit uns, logic [31:0] wd,
                      logic [31:0] exp_d, bit exp_e);
    fix_en = 1;
    fix_d  = exp_d;
    fix_e  = exp_e;
    drive(w, addr, sz, uns, wd);
    fix_en = 0;
  endtask

  task automatic idle(int n);
    req_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic do_reset(int n);
    rst = 1'b1;
    model_reset();
    #1;
    check("async_clr_valid", 32'(rsp_valid), 32'd0);
    check("async_clr_ready", 32'(req_ready), 32'd0);
    repeat (n) step();
    rst = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_addr     = '0;
    req_size     = SIZE_W;
    req_unsigned = 1'b0;
    req_wdata    = '0;
    model_reset();
    step();
    step();
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_error", 32'(rsp_error), 32'd0);
    rst = 1'b0;
    repeat (DEPTH + 2) step();

    for (int w = 0; w < DEPTH; w++) dreq(0, w * 4, 2, 0, 0, 32'h0, 0);
    idle(RL);

    dreq(1, 'h10, 2, 0, 32'hDEADBEEF, 32'h0, 0);
    dreq(0, 'h10, 2, 0, 32'h0, 32'hDEADBEEF, 0);
    dreq(0, 'h13, 0, 0, 32'h0, 32'hFFFFFFDE, 0);
    dreq(0, 'h13, 0, 1, 32'h0, 32'h000000DE, 0);
    dreq(0, 'h10, 1, 0, 32'h0, 32'hFFFFBEEF, 0);
    dreq(0, 'h12, 1, 1, 32'h0, 32'h0000DEAD, 0);
    dreq(1, 'h11, 0, 0, 32'h00000055, 32'h0, 0);
    dreq(0, 'h10, 2, 0, 32'h0, 32'hDEAD55EF, 0);
    dreq(0, 'h11, 1, 0, 32'h0, 32'h0, 1);
    dreq(1, 'h12, 2, 0, 32'h11111111, 32'h0, 1);
    dreq(0, 'h10, 3, 0, 32'h0, 32'h0, 1);
    dreq(1, 'h10, 3, 0, 32'h22222222, 32'h0, 1);
    dreq(0, 'h10, 2, 0, 32'h0, 32'hDEAD55EF, 0);
    dreq(1, 'h12, 1, 0, 32'hFFFFA5C3, 32'h0, 0);
    dreq(0, 'h10, 2, 0, 32'h0, 32'hA5C355EF, 0);
    idle(RL);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        idle(1);
      end else begin
        int sz;
        int a;
        sz = int'($urandom_range(0, 3));
        a  = int'($urandom_range(0, 63));
        if ($urandom_range(0, 3) != 0) a = a & ~((1 << sz) - 1);
        if ($urandom_range(0, 7) == 0) a = int'($urandom_range(0, 1023));
        drive(1'($urandom_range(0, 1)), a, sz, 1'($urandom_range(0, 1)), $urandom());
      end
    end
    idle(RL + 1);

    dreq(1, 'h10, 2, 0, 32'hCAFEF00D, 32'h0, 0);
    drive(0, 'h10, 2, 0, 32'h0);
    drive(0, 'h10, 0, 0, 32'h0);
    drive(0, 'h10, 1, 1, 32'h0);
    do_reset(2);
    for (int n = 0; n < 100; n++) drive(0, int'($urandom_range(0, 255)) * 4, 2, 0, 32'h0);
    do_reset(1);
    for (int n = 0; n < DEPTH - 1; n++) drive(0, int'($urandom_range(0, 255)) * 4, 2, 0, 32'h0);
    idle(RL + 2);
    dreq(0, 'h10, 2, 0, 32'h0, 32'h0, 0);
    dreq(0, 'h13, 0, 0, 32'h0, 32'h0, 0);
    idle(RL + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
